// File: rtl/mem_access_ctrl.sv
// Memory-stage data-bus sequencer: issues one bus request per load/store, stalls the
// pipeline while it is outstanding, aligns store lanes, extracts/extends load data.
module mem_access_ctrl #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              flush,
  input  logic              advance,
  output logic              stall,
  output logic              misalign,
  output logic [XLEN-1:0]   rdata,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t              state_q;
  logic                dreq_valid_q;
  logic [XLEN-1:0]     dreq_addr_q;
  logic [2:0]          dreq_size_q;
  logic [XLEN/8-1:0]   dreq_strobe_q;
  logic [XLEN-1:0]     dreq_data_q;
  logic [XLEN-1:0]     rdata_q;
  logic                is_load_q;
  logic                uns_q;

  logic                access;
  logic                addr_ok;
  logic                accept;
  logic [XLEN/8-1:0]   strobe_d;
  logic [XLEN-1:0]     wdata_d;
  logic [XLEN-1:0]     load_d;

  function automatic logic [XLEN/8-1:0] strobe_base(input logic [1:0] size);
    case (size)
      2'b00:   strobe_base = (XLEN/8)'(8'h01);
      2'b01:   strobe_base = (XLEN/8)'(8'h03);
      2'b10:   strobe_base = (XLEN/8)'(8'h0F);
      default: strobe_base = (XLEN/8)'(8'hFF);
    endcase
  endfunction

  // Bring the addressed lane down to bit 0, truncate to the access size, then extend.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            uns);
    logic [XLEN-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'b00:   extend_load = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'b01:   extend_load = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'b10:   extend_load = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: extend_load = sh;
    endcase
  endfunction

  assign access = in_valid & ((in_op == OP_LOAD) | (in_op == OP_STORE));

  always_comb begin
    addr_ok = 1'b1;
    case (in_size)
      2'b01:   addr_ok = (in_addr[0] == 1'b0);
      2'b10:   addr_ok = (in_addr[1:0] == 2'b00);
      2'b11:   addr_ok = (in_addr[2:0] == 3'b000);
      default: addr_ok = 1'b1;
    endcase
  end

  assign misalign = access & ~addr_ok;
  assign accept   = (state_q == IDLE) & access & ~misalign & ~flush;
  assign stall    = accept | (state_q == BUSY) | (state_q == DRAIN);

  assign strobe_d = strobe_base(in_size) << in_addr[2:0];
  assign wdata_d  = in_wdata << {in_addr[2:0], 3'b000};
  assign load_d   = extend_load(dresp_data, dreq_addr_q[2:0], dreq_size_q[1:0], uns_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      rdata_q       <= '0;
      is_load_q     <= 1'b0;
      uns_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dreq_addr_q   <= in_addr;
            dreq_size_q   <= {1'b0, in_size};
            dreq_strobe_q <= (in_op == OP_STORE) ? strobe_d : '0;
            dreq_data_q   <= wdata_d;
            is_load_q     <= (in_op == OP_LOAD);
            uns_q         <= in_unsigned;
            dreq_valid_q  <= 1'b1;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          if (dresp_data_ok) begin
            dreq_valid_q <= 1'b0;
            if (flush) begin
              state_q <= IDLE;
            end else begin
              if (is_load_q) rdata_q <= load_d;
              state_q <= DONE;
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        // The killed request is still outstanding on the bus; wait it out and drop the data.
        DRAIN: begin
          if (dresp_data_ok) begin
            dreq_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        DONE: begin
          if (advance | flush) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected load results are queued at issue
// and popped when the controller reaches DONE.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        flush;
  logic        advance;
  logic        stall;
  logic        misalign;
  logic [63:0] rdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_rdata = '0;
  logic [63:0] popped;

  mem_access_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .advance(advance), .stall(stall), .misalign(misalign), .rdata(rdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] model_load(logic [63:0] resp, logic [2:0] off,
                                             logic [1:0] size, logic uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = resp[8*(int'(off) + i) +: 8];
    if (!uns && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(logic [2:0] off, logic [1:0] size);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < (1 << size); i++) s[int'(off) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(logic [63:0] w, logic [2:0] off);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) d[8*i +: 8] = w[8*(i - int'(off)) +: 8];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(logic [1:0] op, logic [1:0] size, logic uns, logic [63:0] addr,
                       logic [63:0] wdata);
    in_valid    = 1'b1;
    in_op       = op;
    in_size     = size;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wdata;
  endtask

  task automatic release_stage();
    advance  = 1'b1;
    tick();
    advance  = 1'b0;
    in_valid = 1'b0;
    in_op    = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_op = 2'b00; in_size = 2'b00; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; flush = 1'b0; advance = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (3) tick();
    mid();
    checks++; if (dreq_valid !== 1'b0) begin failures++; $display("FAIL reset_dreq_valid got=%b exp=0", dreq_valid); end
    checks++; if (dreq_addr !== 64'd0) begin failures++; $display("FAIL reset_dreq_addr got=%h exp=0", dreq_addr); end
    checks++; if (dreq_size !== 3'd0) begin failures++; $display("FAIL reset_dreq_size got=%b exp=0", dreq_size); end
    checks++; if (dreq_strobe !== 8'd0) begin failures++; $display("FAIL reset_dreq_strobe got=%h exp=0", dreq_strobe); end
    checks++; if (dreq_data !== 64'd0) begin failures++; $display("FAIL reset_dreq_data got=%h exp=0", dreq_data); end
    checks++; if (rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (stall !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL reset_stall_misalign got=%b%b exp=00", stall, misalign); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_signed_load();
    logic [63:0] resp = 64'h0000_0000_8000_0000;
    exp_q.push_back(model_load(resp, 3'd3, 2'b00, 1'b0));
    drive(2'b01, 2'b00, 1'b0, 64'h1003, '0);
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin failures++; $display("FAIL sload_c0 stall/dv got=%b%b exp=10", stall, dreq_valid); end
    tick();
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b1) begin failures++; $display("FAIL sload_c1 stall/dv got=%b%b exp=11", stall, dreq_valid); end
    checks++; if (dreq_addr !== 64'h1003 || dreq_size !== 3'b000 || dreq_strobe !== 8'h00) begin failures++; $display("FAIL sload_req got addr=%h size=%b strb=%h exp addr=1003 size=000 strb=00", dreq_addr, dreq_size, dreq_strobe); end
    tick();
    dresp_data_ok = 1'b1; dresp_data = resp;
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b1) begin failures++; $display("FAIL sload_c2 stall/dv got=%b%b exp=11", stall, dreq_valid); end
    tick();
    dresp_data_ok = 1'b0;
    mid();
    checks++; if (stall !== 1'b0 || dreq_valid !== 1'b0) begin failures++; $display("FAIL sload_c3 stall/dv got=%b%b exp=00", stall, dreq_valid); end
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL sload_scoreboard_empty got=%h exp=entry", rdata); end
    else begin
      popped = exp_q.pop_front(); exp_rdata = popped;
      checks++; if (rdata !== popped || rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL sload_rdata got=%h exp=%h", rdata, popped); end
    end
    release_stage();
  endtask

  task automatic test_loads();
    logic [63:0] la [8];
    logic [1:0]  ls [8];
    logic        lu [8];
    int          lk [8];
    logic [63:0] resp;
    la = '{64'h100, 64'h106, 64'h104, 64'h105, 64'h102, 64'h100, 64'h107, 64'h1F4};
    ls = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
    lu = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    lk = '{1, 1, 3, 2, 1, 2, 1, 4};
    for (int t = 0; t < 8; t++) begin
      resp = {$urandom, $urandom};
      if (t % 2 == 0) resp = resp | 64'h8080_8080_8080_8080;
      else            resp = resp & 64'h7F7F_7F7F_FFFF_FFFF;
      exp_q.push_back(model_load(resp, la[t][2:0], ls[t], lu[t]));
      drive(2'b01, ls[t], lu[t], la[t], {$urandom, $urandom});
      mid();
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL load%0d_accept_stall got=%b exp=1", t, stall); end
      for (int c = 1; c <= lk[t]; c++) begin
        tick();
        if (c == lk[t]) begin dresp_data_ok = 1'b1; dresp_data = resp; end
        else dresp_data = {$urandom, $urandom};
        mid();
        checks++; if (dreq_valid !== 1'b1 || dreq_addr !== la[t] || dreq_size !== {1'b0, ls[t]}) begin failures++; $display("FAIL load%0d_req_c%0d got dv=%b addr=%h size=%b exp dv=1 addr=%h size=%b", t, c, dreq_valid, dreq_addr, dreq_size, la[t], {1'b0, ls[t]}); end
      end
      tick();
      dresp_data_ok = 1'b0;
      mid();
      checks++; if (stall !== 1'b0 || dreq_valid !== 1'b0) begin failures++; $display("FAIL load%0d_done stall/dv got=%b%b exp=00", t, stall, dreq_valid); end
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL load%0d_scoreboard_empty got=%h exp=entry", t, rdata); end
      else begin
        popped = exp_q.pop_front(); exp_rdata = popped;
        checks++; if (rdata !== popped) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", t, rdata, popped); end
      end
      release_stage();
    end
  endtask

  task automatic test_stores();
    logic [63:0] sa [5];
    logic [1:0]  ss [5];
    logic [63:0] sw [5];
    sa = '{64'h2006, 64'h2004, 64'h2007, 64'h2000, 64'h2003};
    ss = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
    sw = '{64'h1234, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 64'hA5};
    for (int t = 0; t < 5; t++) begin
      drive(2'b10, ss[t], 1'b0, sa[t], sw[t]);
      mid();
      checks++; if (stall !== 1'b1 || misalign !== 1'b0) begin failures++; $display("FAIL store%0d_accept stall/mis got=%b%b exp=10", t, stall, misalign); end
      tick();
      dresp_data_ok = 1'b1;
      mid();
      checks++; if (dreq_valid !== 1'b1 || dreq_addr !== sa[t] || dreq_size !== {1'b0, ss[t]}) begin failures++; $display("FAIL store%0d_req got dv=%b addr=%h size=%b exp dv=1 addr=%h size=%b", t, dreq_valid, dreq_addr, dreq_size, sa[t], {1'b0, ss[t]}); end
      checks++; if (dreq_strobe !== model_strobe(sa[t][2:0], ss[t])) begin failures++; $display("FAIL store%0d_strobe got=%h exp=%h", t, dreq_strobe, model_strobe(sa[t][2:0], ss[t])); end
      checks++; if (dreq_data !== model_wdata(sw[t], sa[t][2:0])) begin failures++; $display("FAIL store%0d_data got=%h exp=%h", t, dreq_data, model_wdata(sw[t], sa[t][2:0])); end
      if (t == 0) begin
        checks++; if (dreq_strobe !== 8'hC0 || dreq_data !== 64'h1234_0000_0000_0000 || dreq_size !== 3'b001) begin failures++; $display("FAIL store_half_fixed got strb=%h data=%h size=%b exp strb=c0 data=1234000000000000 size=001", dreq_strobe, dreq_data, dreq_size); end
      end
      tick();
      dresp_data_ok = 1'b0;
      mid();
      checks++; if (stall !== 1'b0 || dreq_valid !== 1'b0) begin failures++; $display("FAIL store%0d_done stall/dv got=%b%b exp=00", t, stall, dreq_valid); end
      release_stage();
    end
  endtask

  task automatic test_misalign();
    logic [63:0] ma [5];
    logic [1:0]  ms [5];
    logic [1:0]  mo [5];
    logic        me [5];
    ma = '{64'h2002, 64'h2001, 64'h2004, 64'h2006, 64'h2001};
    ms = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    mo = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
    me = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 5; t++) begin
      drive(mo[t], ms[t], 1'b0, ma[t], 64'hFFFF);
      mid();
      checks++; if (misalign !== me[t] || stall !== 1'b0) begin failures++; $display("FAIL misalign%0d mis/stall got=%b%b exp=%b0", t, misalign, stall, me[t]); end
      tick();
      mid();
      checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL misalign%0d_nobus dv/stall got=%b%b exp=00", t, dreq_valid, stall); end
      in_valid = 1'b0;
      tick();
    end
    in_op = 2'b00;
  endtask

  task automatic test_flush_busy();
    logic [63:0] resp;
    drive(2'b01, 2'b11, 1'b0, 64'h3000, '0);
    mid();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_c0_stall got=%b exp=1", stall); end
    tick();
    flush = 1'b1;
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b1) begin failures++; $display("FAIL flush_c1 stall/dv got=%b%b exp=11", stall, dreq_valid); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      flush = 1'b0; in_valid = 1'b0;
      if (c == 4) begin dresp_data_ok = 1'b1; dresp_data = {$urandom, $urandom}; end
      mid();
      checks++; if (stall !== 1'b1 || dreq_valid !== 1'b1) begin failures++; $display("FAIL flush_drain_c%0d stall/dv got=%b%b exp=11", c, stall, dreq_valid); end
    end
    tick();
    dresp_data_ok = 1'b0;
    resp = {$urandom, $urandom};
    exp_q.push_back(model_load(resp, 3'd4, 2'b10, 1'b0));
    drive(2'b01, 2'b10, 1'b0, 64'h3104, '0);
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin failures++; $display("FAIL flush_c5_idle stall/dv got=%b%b exp=10", stall, dreq_valid); end
    checks++; if (rdata !== exp_rdata) begin failures++; $display("FAIL flush_rdata_kept got=%h exp=%h", rdata, exp_rdata); end
    tick();
    dresp_data_ok = 1'b1; dresp_data = resp;
    tick();
    dresp_data_ok = 1'b0;
    mid();
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL flush_next_scoreboard_empty got=%h exp=entry", rdata); end
    else begin
      popped = exp_q.pop_front(); exp_rdata = popped;
      checks++; if (rdata !== popped || stall !== 1'b0) begin failures++; $display("FAIL flush_next_rdata got=%h stall=%b exp=%h stall=0", rdata, stall, popped); end
    end
    release_stage();
    // flush and completion in the same cycle: data dropped, straight back to IDLE
    drive(2'b01, 2'b00, 1'b1, 64'h3201, '0);
    tick();
    flush = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    flush = 1'b0; dresp_data_ok = 1'b0;
    drive(2'b01, 2'b00, 1'b0, 64'h3300, '0);
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0 || rdata !== exp_rdata) begin failures++; $display("FAIL flush_same_cycle got stall=%b dv=%b rdata=%h exp stall=1 dv=0 rdata=%h", stall, dreq_valid, rdata, exp_rdata); end
    in_valid = 1'b0; in_op = 2'b00;
    tick();
  endtask

  task automatic test_done_held();
    logic [63:0] resp;
    resp = {$urandom, $urandom} | 64'h0000_8000_0000_0000;
    exp_q.push_back(model_load(resp, 3'd2, 2'b01, 1'b0));
    drive(2'b01, 2'b01, 1'b0, 64'h4002, '0);
    tick();
    dresp_data_ok = 1'b1; dresp_data = resp;
    tick();
    dresp_data_ok = 1'b0;
    mid();
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL held_scoreboard_empty got=%h exp=entry", rdata); end
    else begin popped = exp_q.pop_front(); exp_rdata = popped; end
    for (int c = 0; c < 3; c++) begin
      checks++; if (stall !== 1'b0 || rdata !== exp_rdata) begin failures++; $display("FAIL held_c%0d got stall=%b rdata=%h exp stall=0 rdata=%h", c, stall, rdata, exp_rdata); end
      if (c < 2) begin
        tick();
        dresp_data_ok = (c == 0);
        dresp_data = ~resp;
        mid();
      end
    end
    dresp_data_ok = 1'b0;
    advance = 1'b1;
    tick();
    advance = 1'b0;
    resp = {$urandom, $urandom};
    exp_q.push_back(model_load(resp, 3'd0, 2'b11, 1'b1));
    drive(2'b01, 2'b11, 1'b1, 64'h4008, '0);
    mid();
    checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin failures++; $display("FAIL held_back_to_idle stall/dv got=%b%b exp=10", stall, dreq_valid); end
    tick();
    dresp_data_ok = 1'b1; dresp_data = resp;
    tick();
    dresp_data_ok = 1'b0;
    mid();
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL b2b_scoreboard_empty got=%h exp=entry", rdata); end
    else begin
      popped = exp_q.pop_front(); exp_rdata = popped;
      checks++; if (rdata !== popped) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", rdata, popped); end
    end
    release_stage();
  endtask

  task automatic test_reset_busy();
    logic [63:0] resp;
    drive(2'b01, 2'b10, 1'b0, 64'h5000, '0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    mid();
    checks++; if (dreq_valid !== 1'b1) begin failures++; $display("FAIL rstbusy_c1_dv got=%b exp=1", dreq_valid); end
    tick();
    reset = 1'b1;
    exp_rdata = '0;
    resp = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    exp_q.push_back(model_load(resp, 3'd4, 2'b10, 1'b0));
    drive(2'b01, 2'b10, 1'b0, 64'h5004, '0);
    mid();
    checks++; if (dreq_valid !== 1'b0 || rdata !== 64'd0 || stall !== 1'b1) begin failures++; $display("FAIL rstbusy_after got dv=%b rdata=%h stall=%b exp dv=0 rdata=0 stall=1", dreq_valid, rdata, stall); end
    tick();
    tick();
    dresp_data_ok = 1'b1; dresp_data = resp;
    tick();
    dresp_data_ok = 1'b0;
    mid();
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rstbusy_scoreboard_empty got=%h exp=entry", rdata); end
    else begin
      popped = exp_q.pop_front(); exp_rdata = popped;
      checks++; if (rdata !== popped || stall !== 1'b0) begin failures++; $display("FAIL rstbusy_next_load got=%h stall=%b exp=%h stall=0", rdata, stall, popped); end
    end
    release_stage();
  endtask

  initial begin
    test_reset();
    test_signed_load();
    test_loads();
    test_stores();
    test_misalign();
    test_flush_busy();
    test_done_held();
    test_reset_busy();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for the memory stage's data-bus accesses. It takes the load/store request carried by the memory stage, issues one request on the data bus, and holds the pipeline while the bus is busy. It also aligns store data and byte strobes, extracts and extends load data, and flags misaligned accesses. It sits between the memory stage datapath, which forwards dst/regwrite/wdata to writeback, the hazard/stall unit and the dbus port.

## Interface
Parameters:
- XLEN, 64, data/address width; fixed at 64 (strobe width XLEN/8 = 8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 = reset at the next rising edge.
- in_valid  in  1  memory stage holds a valid instruction.
- in_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- in_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- in_addr  in  XLEN  effective address.
- in_wdata  in  XLEN  store data, right-aligned.
- flush  in  1  kill the current memory-stage instruction.
- advance  in  1  stage registers update this cycle (from hazard unit).
- stall  out  1  hold all pipeline stages up to and including memory.
- misalign  out  1  current access is misaligned; no bus request is issued.
- rdata  out  XLEN  aligned/extended load result; valid while in DONE.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  XLEN  bus address; the full in_addr is captured, not 8-byte-aligned.
- dreq_size  out  3  {1'b0, in_size}.
- dreq_strobe  out  8  byte enables; 0 for loads.
- dreq_data  out  XLEN  store data shifted into its lane.
- dresp_data_ok  in  1  response/completion for the outstanding request.
- dresp_data  in  XLEN  raw 64-bit read data, lane-aligned.

## Operation
- access = in_valid & (in_op==01 | in_op==10).
- misalign (combinational) = access & the address is not a multiple of the size: half needs addr[0]==0, word needs addr[1:0]==0, dword needs addr[2:0]==0.
- State machine, with states IDLE, BUSY, DRAIN and DONE:
  - IDLE: if access & !misalign & !flush, capture addr, size, op, unsigned, aligned data and strobe into registers, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: dreq_valid=1 with the captured fields held stable.
    - On dresp_data_ok, register the extracted load data into rdata and go to DONE.
    - If flush and !data_ok, go to DRAIN.
    - If flush and data_ok in the same cycle, discard the data and go to IDLE.
  - DRAIN: dreq_valid=1 until dresp_data_ok, then go to IDLE. The response is discarded and rdata is unchanged. flush has no further effect.
  - DONE: if advance or flush, go to IDLE; otherwise hold, with rdata stable.
- stall (combinational):
  - 1 in IDLE when access & !misalign & !flush.
  - 1 in BUSY and in DRAIN.
  - 0 in DONE and in every other case.
- Store alignment:
  - dreq_data = in_wdata << (8*addr[2:0]).
  - dreq_strobe = base << addr[2:0], where base is 0x01, 0x03, 0x0F or 0xFF by size.
- Load extraction:
  - shifted = dresp_data >> (8*addr[2:0]).
  - Truncate shifted to the access size.
  - Zero- or sign-extend the truncated value to 64 bits according to the captured unsigned flag.
- Misaligned access: no state change and no bus traffic; misalign is reported the same cycle for the exception path. in_op 11 is treated as no access.
- Reset has priority over every other input. Any state returns to IDLE and any outstanding request is abandoned: dreq_valid drops the cycle after reset is sampled.

## Timing
- Reset values:
  - state=IDLE, dreq_valid=0, dreq_addr=0, dreq_size=0, dreq_strobe=0, dreq_data=0, rdata=0.
  - stall and misalign follow their combinational equations; both are 0 when in_valid=0.
- dreq_* are registered: the request appears the cycle after IDLE accepts the access.
- Latency, with the request accepted in cycle 0 and dresp_data_ok first high in cycle k ≥ 1:
  - dreq_valid is high in cycles 1..k.
  - DONE is in cycle k+1: stall=0 and rdata is valid.
  - Minimum stall is 2 cycles (k=1).
- dreq_* fields stay stable while dreq_valid=1. dreq_valid drops the cycle after data_ok.
- dresp_data_ok is ignored in IDLE and DONE.
- Upstream in_* signals stay stable while stall=1; the controller does not re-sample them after leaving IDLE.

## Test plan
- Signed byte load:
  - Stimulus: addr 0x1003, dresp_data 0x0000_0000_8000_0000, data_ok in cycle 2.
  - Response: rdata=0xFFFF_FFFF_FFFF_FF80 in cycle 3; stall high in cycles 0–2.
- Store half:
  - Stimulus: addr 0x2006, wdata 0x1234.
  - Response: dreq_strobe=0xC0, dreq_data=0x1234_0000_0000_0000, dreq_size=001.
- Misaligned access:
  - Stimulus: word load at addr 0x2002.
  - Response: misalign=1 and stall=0 in the same cycle; dreq_valid stays 0.
- Flush in BUSY:
  - Stimulus: flush in cycle 1, data_ok in cycle 4.
  - Response: DRAIN with stall=1 through cycle 4; IDLE in cycle 5; rdata unchanged; no DONE.
- DONE held:
  - Stimulus: advance=0 for 3 cycles after completion.
  - Response: DONE held with rdata stable; return to IDLE the cycle after advance=1.
- Reset during BUSY:
  - Stimulus: reset=0 sampled in BUSY.
  - Response: dreq_valid=0, state IDLE and rdata=0 next cycle; a following load completes normally.
